// File: rtl/hpi_pkg.sv
// hpi_pkg: shared state type, I/O latency and HPI register addresses for the HPI transaction sequencer
package hpi_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} hpi_state_t;
    localparam int IO_LAT = 2;
    localparam logic [1:0] HPI_DATA = 2'd0, HPI_MAILBOX = 2'd1, HPI_ADDR = 2'd2, HPI_STATUS = 2'd3;
endpackage

// File: rtl/hpi_arb2.sv
// hpi_arb2: two-way one-hot arbiter; round-robin with HPI_RR_ARB_EN defined, fixed priority (requester 0) otherwise
module hpi_arb2 (
`ifdef HPI_RR_ARB_EN
    input  logic       Clk,
    input  logic       Reset,
`endif
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
`ifdef HPI_RR_ARB_EN
    logic last;  // 1: requester 1 won the previous grant, so requester 0 wins the next tie
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) last <= 1'b1;
        else if (|gnt) last <= gnt[1];
    always_comb gnt = !en ? 2'b00 : (&req) ? (last ? 2'b01 : 2'b10) : req;
`else
    always_comb gnt = !en ? 2'b00 : req[0] ? 2'b01 : req;
`endif
endmodule

// File: rtl/hpi_txn_sequencer.sv
// hpi_txn_sequencer: two-requester HPI transaction sequencer generating timed CS/RD/WR strobes
// HPI_RR_ARB_EN selects round-robin arbitration instead of fixed priority.
module hpi_txn_sequencer
    import hpi_pkg::*;
#(
    parameter int STROBE_CYCLES  = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  addr0,
    input  logic [1:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [1:0]  hpi_address,
    output logic [15:0] hpi_data_out,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_r,
    output logic        hpi_w,
    output logic        hpi_cs
);
    localparam int RD_LEN = STROBE_CYCLES + IO_LAT;
    localparam int CW = $clog2((RD_LEN > RECOVER_CYCLES ? RD_LEN : RECOVER_CYCLES) + 1);
    hpi_state_t state, next_state;
    logic [CW-1:0] cnt;
    logic [1:0] gnt;
    logic we_q, owner, last_cyc;
    hpi_arb2 u_arb (
`ifdef HPI_RR_ARB_EN
        .Clk(Clk),
        .Reset(Reset),
`endif
        .req({req1, req0}),
        .en(state == IDLE && !Reset),
        .gnt(gnt)
    );
    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];
    assign busy = state != IDLE;
    assign last_cyc = cnt == '0;
    always_comb begin
        next_state = state == IDLE   ? (|gnt ? SETUP : IDLE)
                   : state == SETUP  ? STROBE
                   : state == STROBE ? (last_cyc ? RECOVER : STROBE)
                   :                   (last_cyc ? IDLE : RECOVER);
    end
    // Strobes are registered from next_state so they line up with the state they belong to.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            we_q         <= 1'b0;
            owner        <= 1'b0;
            hpi_address  <= '0;
            hpi_data_out <= '0;
            rdata        <= '0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            hpi_cs       <= 1'b1;
            hpi_r        <= 1'b1;
            hpi_w        <= 1'b1;
        end else begin
            state <= next_state;
            cnt <= state == SETUP ? (we_q ? CW'(STROBE_CYCLES - 1) : CW'(RD_LEN - 1))
                 : (state == STROBE && last_cyc) ? CW'(RECOVER_CYCLES - 1)
                 : !last_cyc ? cnt - CW'(1) : cnt;
            if (|gnt) begin
                owner        <= gnt[1];
                we_q         <= gnt[1] ? we1 : we0;
                hpi_address  <= gnt[1] ? addr1 : addr0;
                hpi_data_out <= gnt[1] ? wdata1 : wdata0;
            end
            if (state == STROBE && last_cyc && !we_q) rdata <= hpi_data_in;
            done0  <= state == STROBE && last_cyc && !owner;
            done1  <= state == STROBE && last_cyc && owner;
            hpi_cs <= !(next_state == SETUP || next_state == STROBE);
            hpi_w  <= !(next_state == STROBE && we_q);
            hpi_r  <= !(next_state == STROBE && !we_q);
        end
    end
endmodule

// File: tb/tb_hpi_txn_sequencer.sv
// tb_hpi_txn_sequencer: directed and randomized checks of hpi_txn_sequencer against a cycle-count model
module tb_hpi_txn_sequencer;
    import hpi_pkg::*;
    localparam int N = 4, R = 2, IOL = 2;
    logic Clk = 1'b0, Reset = 1'b1;
    logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [1:0] addr0 = 0, addr1 = 0;
    logic [15:0] wdata0 = 0, wdata1 = 0, hpi_data_in = 0;
    logic gnt0, gnt1, done0, done1, busy, hpi_r, hpi_w, hpi_cs;
    logic [15:0] rdata, hpi_data_out;
    logic [1:0] hpi_address;
    int total = 0, bad = 0, cyc = 0, both_g = 0;
    int n_cs, n_w, n_r, fld_bad;
    int n_g[2], n_d[2], d_cyc[2];
    logic [15:0] exp_wd = 0, exp_rdata = 0;
    logic [1:0] exp_addr = 0;
    bit last_g = 1'b1;

    hpi_txn_sequencer #(.STROBE_CYCLES(N), .RECOVER_CYCLES(R)) dut (
        .Clk(Clk), .Reset(Reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
        .hpi_address(hpi_address), .hpi_data_out(hpi_data_out), .hpi_data_in(hpi_data_in),
        .hpi_r(hpi_r), .hpi_w(hpi_w), .hpi_cs(hpi_cs)
    );

    always #10 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Fields are latched at grant, so the expected address/data follow the granted requester.
    always @(negedge Clk) begin
        if (gnt0) begin n_g[0]++; exp_addr = addr0; exp_wd = wdata0; end
        if (gnt1) begin n_g[1]++; exp_addr = addr1; exp_wd = wdata1; end
        if (gnt0 && gnt1) both_g++;
        if (!hpi_cs) begin n_cs++; if (hpi_address !== exp_addr) fld_bad++; end
        if (!hpi_w) begin n_w++; if (hpi_data_out !== exp_wd) fld_bad++; end
        if (!hpi_r) n_r++;
        if (done0) begin n_d[0]++; d_cyc[0] = cyc; end
        if (done1) begin n_d[1]++; d_cyc[1] = cyc; end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_cs = 0; n_w = 0; n_r = 0; fld_bad = 0;
        n_g[0] = 0; n_g[1] = 0; n_d[0] = 0; n_d[1] = 0; d_cyc[0] = -1; d_cyc[1] = -1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_gnt(output int who, output int at);
        who = -1; at = -1;
        for (int i = 0; i < 40 && who < 0; i++) begin
            @(negedge Clk);
            if (gnt0 || gnt1) begin who = int'(gnt1); at = cyc; end
        end
        if (who < 0) chk("gnt_timeout", 0, 1);
        step(1);
    endtask

    task automatic wait_idle(output int at);
        at = -1;
        for (int i = 0; i < 40 && at < 0; i++) begin
            @(negedge Clk);
            if (!busy) at = cyc;
        end
        if (at < 0) chk("idle_timeout", 0, 1);
        step(1);
    endtask

    task automatic do_txn(input string tag, input int k, input logic we, input logic [1:0] a,
                          input logic [15:0] wd, input logic [15:0] din);
        int who, g, f, len;
        clr();
        hpi_data_in = din;
        if (k == 1) begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
        else begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
        wait_gnt(who, g);
        req0 = 0; req1 = 0;
        wait_idle(f);
        len = we ? N : N + IOL;
        if (!we) exp_rdata = din;
        last_g = k[0];
        chk({tag, "_owner"}, who, k);
        chk({tag, "_cs_cycles"}, n_cs, len + 1);
        chk({tag, "_w_cycles"}, n_w, we ? N : 0);
        chk({tag, "_r_cycles"}, n_r, we ? 0 : N + IOL);
        chk({tag, "_done_own"}, n_d[k], 1);
        chk({tag, "_done_other"}, n_d[1-k], 0);
        chk({tag, "_done_cyc"}, d_cyc[k] - g, 2 + len);
        chk({tag, "_busy_fall"}, f - g, 2 + len + R);
        chk({tag, "_fields"}, fld_bad, 0);
        chk({tag, "_rdata"}, rdata, exp_rdata);
    endtask

    initial begin
        int who, g, g0, g1, f, prev, e;
        logic [15:0] r2;
        clr();
        step(3);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", hpi_address, 0);
        chk("rst_dout", hpi_data_out, 0);
        chk("rst_strobes", {hpi_r, hpi_w, hpi_cs}, 3'b111);
        Reset = 0;
        step(2);

        do_txn("wr0", 0, 1'b1, HPI_ADDR, 16'h1000, 16'h0);
        do_txn("rd1", 1, 1'b0, HPI_DATA, 16'h0, 16'hBEEF);
        do_txn("wr1_hold", 1, 1'b1, HPI_MAILBOX, 16'(urand16()), 16'(urand16()));

        // Reset during the STROBE phase of a read
        clr();
        hpi_data_in = 16'h1234; req1 = 1; we1 = 0; addr1 = HPI_STATUS;
        wait_gnt(who, g);
        req1 = 0;
        step(2);
        chk("rst_mid_pre_r", hpi_r, 0);
        #3 Reset = 1;
        #1;
        chk("rst_mid_strobes", {hpi_r, hpi_w, hpi_cs}, 3'b111);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rdata", rdata, 0);
        chk("rst_mid_addr", hpi_address, 0);
        exp_rdata = 0; last_g = 1'b1;
        step(2);
        Reset = 0;
        step(10);
        chk("rst_mid_no_done", n_d[0] + n_d[1], 0);

        // Both requesters held, four contested grants then requester 0 withdraws
        clr();
        req0 = 1; req1 = 1; we0 = 1; we1 = 1; addr0 = HPI_MAILBOX; addr1 = HPI_STATUS;
        wdata0 = 16'h0A0A; wdata1 = 16'h5151;
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(who, g);
`ifdef HPI_RR_ARB_EN
            e = (i == 4) ? 1 : (last_g ? 0 : 1);
`else
            e = (i == 4) ? 1 : 0;
`endif
            chk($sformatf("arb_%0d", i), who, e);
            if (prev >= 0) chk($sformatf("arb_gap_%0d", i), g - prev, 2 + N + R);
            prev = g;
            last_g = who[0];
            if (i == 3) req0 = 0;
            if (i == 4) req1 = 0;
        end
        wait_idle(f);
        chk("arb_dones", n_d[0] + n_d[1], 5);
        chk("arb_fields", fld_bad, 0);

        do_txn("post_rst_rd", 1, 1'b0, HPI_DATA, 16'h0, 16'(urand16()));

        // Request raised while busy is served in the first IDLE cycle
        clr();
        r2 = 16'(urand16());
        req0 = 1; we0 = 1; addr0 = HPI_ADDR; wdata0 = 16'(urand16());
        wait_gnt(who, g0);
        req0 = 0;
        chk("held_first", who, 0);
        step(2);
        req1 = 1; we1 = 0; addr1 = HPI_DATA; hpi_data_in = r2;
        wait_gnt(who, g1);
        req1 = 0;
        wait_idle(f);
        exp_rdata = r2; last_g = 1'b1;
        chk("held_second", who, 1);
        chk("held_gap", g1 - g0, 2 + N + R);
        chk("held_cs_total", n_cs, (N + 1) + (N + IOL + 1));
        chk("held_rdata", rdata, exp_rdata);

        // One-cycle req1 blip while busy is withdrawn
        clr();
        req0 = 1; we0 = 1; addr0 = HPI_STATUS; wdata0 = 16'(urand16());
        wait_gnt(who, g);
        req0 = 0;
        step(2);
        req1 = 1; we1 = 1; addr1 = HPI_DATA;
        step(1);
        req1 = 0;
        wait_idle(f);
        step(4);
        last_g = 1'b0;
        chk("blip_gnt1", n_g[1], 0);
        chk("blip_done1", n_d[1], 0);
        chk("blip_cs", n_cs, N + 1);
        chk("blip_done0", n_d[0], 1);

        for (int i = 0; i < 6; i++) begin
            int k;
            logic w;
            k = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            do_txn($sformatf("rnd%0d", i), k, w, 2'($urandom_range(0, 3)), 16'(urand16()), 16'(urand16()));
        end

        chk("never_both_gnt", both_g, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic int urand16();
        return int'($urandom_range(0, 65535));
    endfunction
endmodule

// File: doc/hpi_txn_sequencer.md
# hpi_txn_sequencer

- Two-requester transaction sequencer for the CY7C67200 host port interface (HPI).
- Sits between requesters (e.g. the NIOS software bridge and the hardware keyboard/USB poller) and the registered HPI I/O interface block, driving its `from_sw_*` side.
- Arbitrates requests and generates timed CS/RD/WR strobe sequences. Returns read data with a completion pulse.
- Replaces hand-bit-banged strobes with a fixed, parameterised cycle sequence.

## Interface
Parameters:
- `STROBE_CYCLES`, 4: cycles RD/WR is held asserted for a write (min 1).
- `RECOVER_CYCLES`, 2: cycles CS is deasserted between transactions (min 1).

Ports:
- `Clk`  in  1  system clock (50 MHz); single clock domain.
- `Reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  level request; hold until `gnt_k`.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  2  HPI register address.
- `wdata0`, `wdata1`  in  16  write data.
- `gnt0`, `gnt1`  out  1  one-cycle pulse; request accepted, fields latched.
- `done0`, `done1`  out  1  one-cycle pulse; transaction complete.
- `rdata`  out  16  read data, valid from `done_k` until next read completes.
- `busy`  out  1  high in any non-IDLE state.
- `hpi_address`  out  2  to I/O interface address.
- `hpi_data_out`  out  16  to I/O interface write data.
- `hpi_data_in`  in  16  from I/O interface (registered pin data).
- `hpi_r`, `hpi_w`, `hpi_cs`  out  1  active-low strobes to I/O interface.

## Operation
- Reset values: `gnt*`=0, `done*`=0, `rdata`=0, `busy`=0, `hpi_address`=0, `hpi_data_out`=0, `hpi_r`=`hpi_w`=`hpi_cs`=1.
- States: IDLE, SETUP, STROBE, RECOVER.
- IDLE:
  - If any `req_k` is high, the arbiter picks a winner and pulses `gnt_k`.
  - `addr`, `we`, `wdata` and the owner ID are latched; next state is SETUP.
  - Otherwise the block stays in IDLE.
- SETUP, 1 cycle:
  - `hpi_cs`=0 and `hpi_address`/`hpi_data_out` are driven.
  - `hpi_r`=`hpi_w`=1.
- STROBE:
  - `hpi_cs`=0, and `hpi_w`=0 (write) or `hpi_r`=0 (read).
  - Length is `STROBE_CYCLES` for a write.
  - Length is `STROBE_CYCLES`+`IO_LAT` for a read, so the doubly registered pin data returns while RD_N is still low at the pin.
  - A down-counter sized $clog2(`STROBE_CYCLES`+`IO_LAT`+1) loads on SETUP exit.
  - On a read, `hpi_data_in` is captured into `rdata` on the final STROBE edge.
- RECOVER, `RECOVER_CYCLES` cycles:
  - All strobes are high. `done_owner` pulses in the first RECOVER cycle. Next state is IDLE.
- `hpi_address` and `hpi_data_out` hold their latched values from SETUP through RECOVER.
- Requests asserted while `busy` wait; they are evaluated in the next IDLE cycle.
- Dropping `req_k` before `gnt_k` withdraws the request without side effects.
- Requester fields must be stable while `req_k`=1 and not yet granted.

## Timing
- Write: `gnt` at cycle 0; SETUP is cycle 1; STROBE is cycles 2..1+N; `done` at cycle 2+N; IDLE at 2+N+R. Defaults give 8 cycles total.
- Read: the same sequence with N+2 strobe cycles, so `done` is at cycle 4+N (cycle 8 with defaults) and the total is 10 cycles.
- Strobes are registered outputs of this block; the I/O interface adds one further register stage to the pins.
- Simultaneous requests in IDLE: exactly one grant per transaction, and never both `gnt0` and `gnt1` in the same cycle.
- Reset asserted mid-transaction: all outputs return to their reset values immediately (asynchronous). The transaction is dropped and no `done` is issued. The arbiter pointer resets to favour requester 0.

## Configuration
- `HPI_RR_ARB_EN` defined: round-robin arbitration.
  - When both requesters are pending, the one not granted last wins.
  - A one-bit last-grant pointer updates on each grant.
- `HPI_RR_ARB_EN` undefined: fixed priority. Requester 0 always wins ties and there is no pointer state.

## Structure
- Package `hpi_pkg` holds:
  - the state enum `hpi_state_t`;
  - `IO_LAT` = 2;
  - HPI address constants `HPI_DATA`=2'd0, `HPI_MAILBOX`=2'd1, `HPI_ADDR`=2'd2, `HPI_STATUS`=2'd3.
- Sub-module `hpi_arb2`: 2-way arbiter that takes the req vector and the enable, and returns a one-hot grant. It contains the `HPI_RR_ARB_EN` pointer logic.
- The sequencer FSM, counter and latches live in the top module.

## Test plan
- Write from requester 0 with `addr0`=`HPI_ADDR`, `wdata0`=16'h1000:
  - `gnt0` pulses at cycle 0.
  - `hpi_cs`=0 for cycles 1..5.
  - `hpi_w`=0 for exactly 4 cycles (2..5), with `hpi_data_out`=16'h1000 throughout.
  - `done0` pulses at cycle 6 and `busy` falls at cycle 8.
- Read from requester 1 at `HPI_DATA`, with the bench model returning 16'hBEEF on `hpi_data_in`:
  - `hpi_r`=0 for 6 cycles.
  - `done1` pulses at cycle 8 with `rdata`=16'hBEEF.
  - `rdata` holds through a following write.
- Both requests raised in the same cycle, repeated 4 times:
  - With `HPI_RR_ARB_EN` defined, grants alternate 0,1,0,1.
  - With it undefined, grants go 0,0,0,0, and requester 1 is served only after `req0` drops.
- Request held during a busy transaction: the grant occurs in the first IDLE cycle after RECOVER, and there is never an overlap of `hpi_cs`=0 windows.
- Reset asserted during STROBE of a read: all strobes go to 1 asynchronously, no `done` pulse, and `rdata`=0. The next request completes normally.
- `req1` raised for 1 cycle while the block is busy, then dropped: no `gnt1` and no HPI activity for requester 1.
